// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU: opcodes, ALU select codes,
// sequencer state encoding and the latched decoder-control bundle.
package cpu_pkg;

  // Instruction opcodes (ir[7:4])
  localparam logic [3:0] OP_NOP      = 4'b0000;
  localparam logic [3:0] OP_LOAD_R0  = 4'b0001;
  localparam logic [3:0] OP_LOAD_R1  = 4'b1001;
  localparam logic [3:0] OP_STORE_R0 = 4'b0010;
  localparam logic [3:0] OP_STORE_R1 = 4'b1010;
  localparam logic [3:0] OP_ADD      = 4'b0011;
  localparam logic [3:0] OP_SUB      = 4'b0100;
  localparam logic [3:0] OP_AND      = 4'b0101;
  localparam logic [3:0] OP_OR       = 4'b0110;
  localparam logic [3:0] OP_XOR      = 4'b0111;
  localparam logic [3:0] OP_HALT     = 4'b1111;

  // ALU select codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXEC      = 3'd3;
  localparam logic [2:0] ST_MEM       = 3'd4;
  localparam logic [2:0] ST_WB        = 3'd5;
  localparam logic [2:0] ST_HALT      = 3'd6;
  localparam logic [2:0] ST_STEP_WAIT = 3'd7;

  // Decoder outputs captured in DECODE and held for the rest of the instruction
  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_sel;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_inc;
  } ctrl_t;

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// Data-memory handshake bus between the sequencer (master) and data memory (slave).
interface cpu_seq_ctrl_if;
  logic       dmem_req;
  logic       dmem_we;
  logic [3:0] dmem_addr;
  logic       dmem_ack;

  modport master (output dmem_req, output dmem_we, output dmem_addr, input dmem_ack);
  modport slave  (input dmem_req, input dmem_we, input dmem_addr, output dmem_ack);
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for the 8-bit-instruction mini CPU. Owns PC and IR,
// feeds ir[7:4] to the external decoder, latches its controls and produces
// timed strobes for the register file, ALU and handshaked data memory.
// Optional feature macro: SINGLE_STEP_EN (adds `step` input and STEP_WAIT state).
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [PC_W-1:0]  imem_addr,
  input  logic [7:0]       imem_data,
  output logic [3:0]       dec_opcode,
  input  logic             dec_reg_write,
  input  logic             dec_reg_sel,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_pc_inc,
  input  logic             dec_halt,
  input  logic [2:0]       dec_alu_op,
  output logic [2:0]       alu_op,
  output logic             rf_we,
  output logic             rf_sel,
  output logic             rf_src,
  cpu_seq_ctrl_if.master   dmem,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  logic [2:0]       state;
  logic [PC_W-1:0]  pc;
  logic [7:0]       ir;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] ret_cnt;

  // After an instruction retires, single-step builds park in STEP_WAIT
  // instead of fetching straight away.
`ifdef SINGLE_STEP_EN
  localparam logic [2:0] ST_RETIRE_NEXT = ST_STEP_WAIT;
`else
  localparam logic [2:0] ST_RETIRE_NEXT = ST_FETCH;
`endif

  // Sequencer state, PC, IR, latched decoder controls and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      ir      <= '0;
      ctrl    <= '0;
      ret_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          ir    <= imem_data;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          ctrl <= '{alu_op:    dec_alu_op,
                    reg_sel:   dec_reg_sel,
                    mem_read:  dec_mem_read,
                    mem_write: dec_mem_write,
                    reg_write: dec_reg_write,
                    pc_inc:    dec_pc_inc};
          if (dec_halt)                          state <= ST_HALT;
          else if (dec_mem_read || dec_mem_write) state <= ST_MEM;
          else                                   state <= ST_EXEC;
        end
        ST_EXEC: begin
          pc      <= pc + PC_W'(ctrl.pc_inc);
          ret_cnt <= ret_cnt + CNT_W'(1);
          state   <= ST_RETIRE_NEXT;
        end
        ST_MEM: begin
          // Bus fields come straight from state/ir/ctrl, so they hold until ack.
          if (dmem.dmem_ack) begin
            if (ctrl.mem_read && !ctrl.mem_write) begin
              state <= ST_WB;
            end else begin
              pc      <= pc + PC_W'(1);
              ret_cnt <= ret_cnt + CNT_W'(1);
              state   <= ST_RETIRE_NEXT;
            end
          end
        end
        ST_WB: begin
          pc      <= pc + PC_W'(1);
          ret_cnt <= ret_cnt + CNT_W'(1);
          state   <= ST_RETIRE_NEXT;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
`ifdef SINGLE_STEP_EN
        ST_STEP_WAIT: begin
          if (step) state <= ST_FETCH;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they drop with async reset
  assign imem_addr      = pc;
  assign dec_opcode     = ir[7:4];
  assign alu_op         = ctrl.alu_op;
  assign rf_sel         = ctrl.reg_sel;
  assign rf_we          = ((state == ST_EXEC) && ctrl.reg_write) || (state == ST_WB);
  assign rf_src         = (state == ST_WB);
  assign dmem.dmem_req  = (state == ST_MEM);
  assign dmem.dmem_we   = (state == ST_MEM) && ctrl.mem_write;
  assign dmem.dmem_addr = ir[3:0];
  assign halted         = (state == ST_HALT);
  assign busy           = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_STEP_WAIT);
  assign retired        = ret_cnt;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed scenarios plus a randomized
// program run, checked per cycle against an instruction-level model.
module tb_cpu_seq_ctrl;
  import cpu_pkg::*;

  localparam int PC_W  = 4;
  localparam int CNT_W = 8;

  localparam int K_NOP   = 0;
  localparam int K_ALU   = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;
  localparam int K_HALT  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic [PC_W-1:0]  imem_addr;
  logic [7:0]       imem_data;
  logic [3:0]       dec_opcode;
  logic             dec_reg_write, dec_reg_sel, dec_mem_read, dec_mem_write, dec_pc_inc, dec_halt;
  logic [2:0]       dec_alu_op;
  logic [2:0]       alu_op;
  logic             rf_we, rf_sel, rf_src;
  logic             halted, busy;
  logic [CNT_W-1:0] retired;
`ifdef SINGLE_STEP_EN
  logic             step = 1'b1;
`endif

  cpu_seq_ctrl_if dmem_bus ();

  cpu_seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
`ifdef SINGLE_STEP_EN
    .step          (step),
`endif
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .dec_opcode    (dec_opcode),
    .dec_reg_write (dec_reg_write),
    .dec_reg_sel   (dec_reg_sel),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_pc_inc    (dec_pc_inc),
    .dec_halt      (dec_halt),
    .dec_alu_op    (dec_alu_op),
    .alu_op        (alu_op),
    .rf_we         (rf_we),
    .rf_sel        (rf_sel),
    .rf_src        (rf_src),
    .dmem          (dmem_bus),
    .halted        (halted),
    .busy          (busy),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  // Combinational instruction ROM
  logic [7:0] rom [16];
  assign imem_data = rom[imem_addr];

  // Stand-in for the external instruction decoder
  always_comb begin
    dec_reg_write = 1'b0;
    dec_reg_sel   = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_pc_inc    = 1'b1;
    dec_halt      = 1'b0;
    dec_alu_op    = ALU_ADD;
    case (dec_opcode)
      OP_LOAD_R0:  dec_mem_read = 1'b1;
      OP_LOAD_R1:  begin dec_mem_read = 1'b1; dec_reg_sel = 1'b1; end
      OP_STORE_R0: dec_mem_write = 1'b1;
      OP_STORE_R1: begin dec_mem_write = 1'b1; dec_reg_sel = 1'b1; end
      OP_ADD:      begin dec_reg_write = 1'b1; dec_alu_op = ALU_ADD; end
      OP_SUB:      begin dec_reg_write = 1'b1; dec_alu_op = ALU_SUB; end
      OP_AND:      begin dec_reg_write = 1'b1; dec_alu_op = ALU_AND; end
      OP_OR:       begin dec_reg_write = 1'b1; dec_alu_op = ALU_OR;  end
      OP_XOR:      begin dec_reg_write = 1'b1; dec_alu_op = ALU_XOR; end
      OP_HALT:     begin dec_halt = 1'b1; dec_pc_inc = 1'b0; end
      default:     ;
    endcase
  end

  int errors = 0;
  int checks = 0;

  // Architectural model state: where the program is and how many retired
  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction class from the opcode table
  function automatic int kind(input logic [3:0] op);
    case (op)
      4'h1, 4'h9:                   return K_LOAD;
      4'h2, 4'hA:                   return K_STORE;
      4'h3, 4'h4, 4'h5, 4'h6, 4'h7: return K_ALU;
      4'hF:                         return K_HALT;
      default:                      return K_NOP;
    endcase
  endfunction

  // Reset, then raise run so the next cycle is FETCH at address 0
  task automatic start_run();
    rst = 1'b1;
    run = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    run = 1'b1;
    tick();
    m_pc  = '0;
    m_ret = '0;
  endtask

  // Step one instruction from its FETCH cycle, checking every cycle it occupies.
  // mem_cycles: number of MEM cycles (ack lands in the last). spurious: ack pulse in FETCH.
  task automatic run_instr(input int mem_cycles, input bit spurious);
    logic [7:0] instr;
    int k;
    instr = rom[m_pc];
    k = kind(instr[7:4]);

    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_retired", retired, m_ret);
    chk("fetch_busy", busy, 1);
    chk("fetch_halted", halted, 0);
    chk("fetch_strobes", {rf_we, dmem_bus.dmem_req}, 0);
    if (spurious) dmem_bus.dmem_ack = 1'b1;
    tick();
    dmem_bus.dmem_ack = 1'b0;

    chk("dec_opcode", dec_opcode, instr[7:4]);
    chk("decode_strobes", {rf_we, dmem_bus.dmem_req}, 0);
    tick();

    if (k == K_NOP || k == K_ALU) begin
      chk("exec_rf_we", rf_we, (k == K_ALU));
      chk("exec_rf_src", rf_src, 0);
      chk("exec_req", dmem_bus.dmem_req, 0);
      if (k == K_ALU) begin
        chk("exec_alu_op", alu_op, instr[7:4] - 4'd3);
        chk("exec_rf_sel", rf_sel, 0);
      end
      tick();
      m_pc++;
      m_ret++;
    end else if (k == K_LOAD || k == K_STORE) begin
      for (int c = 0; c < mem_cycles; c++) begin
        chk("mem_req", dmem_bus.dmem_req, 1);
        chk("mem_we", dmem_bus.dmem_we, (k == K_STORE));
        chk("mem_addr", dmem_bus.dmem_addr, instr[3:0]);
        chk("mem_rf_we", rf_we, 0);
        if (c == mem_cycles - 1) dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
      end
      if (k == K_LOAD) begin
        chk("wb_rf_we", rf_we, 1);
        chk("wb_rf_src", rf_src, 1);
        chk("wb_rf_sel", rf_sel, instr[7]);
        chk("wb_req", dmem_bus.dmem_req, 0);
        tick();
      end
      m_pc++;
      m_ret++;
    end else begin
      for (int c = 0; c < 4; c++) begin
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_pc", imem_addr, m_pc);
        chk("halt_retired", retired, m_ret);
        chk("halt_strobes", {rf_we, dmem_bus.dmem_req}, 0);
        run = ~run;
        tick();
      end
    end
`ifdef SINGLE_STEP_EN
    if (k != K_HALT) begin
      chk("step_wait_busy", busy, 0);
      tick();
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    // Reset with run low: stays IDLE at pc 0
    rst = 1'b1;
    run = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    chk("idle_pc", imem_addr, 0);
    chk("idle_retired", retired, 0);
    chk("idle_halted", halted, 0);
    chk("idle_strobes", {rf_we, rf_src, dmem_bus.dmem_req, dmem_bus.dmem_we}, 0);
    run = 1'b1;
    tick();
    chk("run_busy", busy, 1);
    chk("run_addr", imem_addr, 0);

    // ALU op: ADD
    rom[0] = 8'h30;
    start_run();
    run_instr(1, 1'b0);
    chk("add_pc", imem_addr, 1);
    chk("add_retired", retired, 1);

    // Load R1,[5] with three MEM cycles and a spurious ack in FETCH
    rom[0] = 8'h95;
    start_run();
    run_instr(3, 1'b1);
    chk("load_pc", imem_addr, 1);

    // Store R0,[7] acknowledged in its first MEM cycle
    rom[0] = 8'h27;
    start_run();
    run_instr(1, 1'b0);
    chk("store_pc", imem_addr, 1);

    // NOP run across the PC wrap, then HALT at address 1
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    start_run();
    for (int i = 0; i < 16; i++) run_instr(1, 1'b0);
    chk("wrap_pc", imem_addr, 0);
    run_instr(1, 1'b0);
    rom[1] = 8'hF0;
    run_instr(1, 1'b0);
    chk("halt_final_retired", retired, 17);
    chk("halt_final_pc", imem_addr, 1);

    // Reset in the middle of a memory transaction
    rom[0] = 8'h00;
    rom[1] = 8'h13;
    start_run();
    run_instr(1, 1'b0);
    tick();
    tick();
    chk("midmem_req_before", dmem_bus.dmem_req, 1);
    tick();
    rst = 1'b1;
    run = 1'b0;
    #1;
    chk("midmem_req_async", dmem_bus.dmem_req, 0);
    chk("midmem_busy", busy, 0);
    chk("midmem_pc", imem_addr, 0);
    chk("midmem_retired", retired, 0);
    #2;
    rst = 1'b0;
    tick();
    tick();
    chk("midmem_idle_busy", busy, 0);
    run = 1'b1;
    tick();
    chk("midmem_restart_busy", busy, 1);

    // Random program: every non-HALT opcode (incl. unknown ones), random waits,
    // long enough to wrap both the PC and the retired counter
    start_run();
    for (int n = 0; n < 300; n++) begin
      rom[m_pc] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      run = 1'($urandom_range(0, 1));
      run_instr($urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
    rom[m_pc] = 8'hF0;
    run_instr(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
